// File: rtl/snn_pkg.sv
// Shared types, default widths and helpers for the spiking neuron stages.
package snn_pkg;

  typedef enum logic {
    ST_INTEG  = 1'b0,
    ST_REFRAC = 1'b1
  } state_t;

  localparam int DEF_W_WIDTH = 4;
  localparam int DEF_V_WIDTH = 8;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned       width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi)
      return hi;
    else if (value < lo)
      return lo;
    else
      return value;
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Combinational saturating signed add of a membrane potential and a synaptic weight.
module sat_accum
  import snn_pkg::*;
#(
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int V_WIDTH = DEF_V_WIDTH
) (
  input  logic [V_WIDTH-1:0] v_in,
  input  logic [W_WIDTH-1:0] weight,
  input  logic               en,
  output logic [V_WIDTH-1:0] sum
);

  logic signed [V_WIDTH:0] ext_v;
  logic signed [V_WIDTH:0] ext_w;
  logic signed [V_WIDTH:0] raw;
  logic signed [31:0]      clamped;

  always_comb begin
    ext_v   = (V_WIDTH+1)'($signed(v_in));
    ext_w   = en ? (V_WIDTH+1)'($signed(weight)) : '0;
    raw     = ext_v + ext_w;
    clamped = sat_signed(32'(raw), V_WIDTH);
    sum     = clamped[V_WIDTH-1:0];
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating integration, shift leak on tick,
// one-cycle spike on threshold crossing, then a tick-counted refractory hold-off.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int W_WIDTH    = DEF_W_WIDTH,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] in_weight,
  input  logic               tick,
  output logic               spike_out,
  output logic [V_WIDTH-1:0] v_mem,
  output logic               refrac_active
);

  localparam int CW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
  localparam logic [CW-1:0]             REFRAC_LD = CW'(REFRAC);
  localparam logic signed [V_WIDTH-1:0] THR       = V_WIDTH'(THRESH);

  state_t                      state, state_n;
  logic signed [V_WIDTH-1:0]   v_reg, v_n;
  logic                        spike_n;
  logic [CW-1:0]               cnt, cnt_n;
  logic                        xfer;
  logic [V_WIDTH-1:0]          sum_raw;
  logic signed [V_WIDTH-1:0]   sum;
  logic signed [V_WIDTH-1:0]   lk;

  assign in_ready      = (state == ST_INTEG);
  assign refrac_active = (state == ST_REFRAC);
  assign v_mem         = v_reg;
  assign xfer          = in_valid && in_ready;

  sat_accum #(
    .W_WIDTH (W_WIDTH),
    .V_WIDTH (V_WIDTH)
  ) u_accum (
    .v_in   (v_reg),
    .weight (in_weight),
    .en     (xfer),
    .sum    (sum_raw)
  );

  // Leak is applied to the post-integration value so add, leak and compare
  // all resolve in the same cycle.
  always_comb begin
    sum = $signed(sum_raw);
    lk  = sum - (sum >>> LEAK_SHIFT);
  end

  always_comb begin
    state_n = state;
    v_n     = v_reg;
    spike_n = 1'b0;
    cnt_n   = cnt;
    unique case (state)
      ST_INTEG: begin
        if (tick) begin
          if (lk >= THR) begin
            spike_n = 1'b1;
            v_n     = '0;
            if (REFRAC > 0) begin
              state_n = ST_REFRAC;
              cnt_n   = REFRAC_LD;
            end
          end else begin
            v_n = lk;
          end
        end else begin
          v_n = sum;
        end
      end
      ST_REFRAC: begin
        v_n = '0;
        if (tick) begin
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1))
            state_n = ST_INTEG;
        end
      end
      default: begin
        state_n = ST_INTEG;
        v_n     = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INTEG;
      v_reg     <= '0;
      spike_out <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      v_reg     <= v_n;
      spike_out <= spike_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with an integer-arithmetic reference model.
module tb_lif_neuron;

  localparam int TH  = 64;
  localparam int REF = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_weight;
  logic       tick;
  logic       spike_out;
  logic [7:0] v_mem;
  logic       refrac_active;

  int n_cmp;
  int n_bad;

  // reference model state
  int m_v;
  bit m_spike;
  bit m_refr;
  int m_cnt;

  lif_neuron #(
    .W_WIDTH    (4),
    .V_WIDTH    (8),
    .THRESH     (64),
    .LEAK_SHIFT (3),
    .REFRAC     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_weight     (in_weight),
    .tick          (tick),
    .spike_out     (spike_out),
    .v_mem         (v_mem),
    .refrac_active (refrac_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int floor_div8(input int x);
    if (x < 0 && (x % 8) != 0) return x / 8 - 1;
    return x / 8;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vm();
    return int'($signed(v_mem));
  endfunction

  task automatic model_reset();
    m_v = 0; m_spike = 0; m_refr = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic step(input bit v, input int w, input bit t);
    int s, l, wv;
    @(negedge clk);
    in_valid  = v;
    in_weight = 4'(w);
    tick      = t;
    @(posedge clk);
    wv = int'($signed(in_weight));
    m_spike = 0;
    if (!m_refr) begin
      s = v ? clamp8(m_v + wv) : m_v;
      if (t) begin
        l = s - floor_div8(s);
        if (l >= TH) begin
          m_spike = 1;
          m_v = 0;
          if (REF > 0) begin m_refr = 1; m_cnt = REF; end
        end else begin
          m_v = l;
        end
      end else begin
        m_v = s;
      end
    end else begin
      m_v = 0;
      if (t) begin
        m_cnt--;
        if (m_cnt == 0) m_refr = 0;
      end
    end
    #1;
    chk("v_mem", vm(), m_v);
    chk("spike_out", int'(spike_out), int'(m_spike));
    chk("in_ready", int'(in_ready), int'(!m_refr));
    chk("refrac_active", int'(refrac_active), int'(m_refr));
  endtask

  task automatic steps(input int n, input int w);
    for (int i = 0; i < n; i++) step(1'b1, w, 1'b0);
  endtask

  // Async reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 0; tick = 0; in_weight = '0;
    #1;
    model_reset();
    chk("rst_v_mem", vm(), 0);
    chk("rst_spike", int'(spike_out), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_refrac", int'(refrac_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 0; tick = 0; in_weight = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_v_mem", vm(), 0);
    chk("por_in_ready", int'(in_ready), 1);
    chk("por_refrac", int'(refrac_active), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // integrate and leak
    steps(5, 7);
    chk("int35", vm(), 35);
    chk("int35_nospike", int'(spike_out), 0);
    step(1'b0, 0, 1'b1);
    chk("leak31", vm(), 31);

    // reset with accumulated potential
    async_reset();

    // fire and refractory, upstream holding a weight throughout
    steps(11, 7);
    chk("int77", vm(), 77);
    step(1'b1, 7, 1'b1);
    chk("fire_spike", int'(spike_out), 1);
    chk("fire_v0", vm(), 0);
    chk("fire_refrac", int'(refrac_active), 1);
    chk("fire_notready", int'(in_ready), 0);
    step(1'b1, 7, 1'b0);
    chk("spike_one_cycle", int'(spike_out), 0);
    chk("refrac_hold_v", vm(), 0);
    step(1'b1, 7, 1'b1);
    chk("refrac_after1", int'(refrac_active), 1);
    step(1'b1, 7, 1'b0);
    step(1'b1, 7, 1'b1);
    chk("refrac_done", int'(refrac_active), 0);
    chk("ready_again", int'(in_ready), 1);
    chk("held_v0", vm(), 0);
    step(1'b1, 7, 1'b0);
    chk("resume7", vm(), 7);

    // reset while refractory
    steps(10, 7);
    step(1'b1, 7, 1'b1);
    chk("refire_refrac", int'(refrac_active), 1);
    async_reset();

    // saturation
    steps(20, 7);
    chk("sat_hi", vm(), 127);
    steps(40, -8);
    chk("sat_lo", vm(), -128);

    // simultaneous transfer and tick
    async_reset();
    steps(8, 7); steps(1, 4);
    chk("pre60", vm(), 60);
    step(1'b1, 7, 1'b1);
    chk("sim60_v", vm(), 59);
    chk("sim60_nospike", int'(spike_out), 0);

    async_reset();
    steps(9, 7); steps(1, 1);
    chk("pre64", vm(), 64);
    step(1'b1, 7, 1'b1);
    chk("sim64_v", vm(), 63);
    chk("sim64_nospike", int'(spike_out), 0);

    async_reset();
    steps(9, 7); steps(1, 3);
    chk("pre66", vm(), 66);
    step(1'b1, 7, 1'b1);
    chk("sim66_spike", int'(spike_out), 1);
    chk("sim66_v", vm(), 0);

    // negative leak
    async_reset();
    steps(1, -8); steps(1, -1);
    chk("pre_neg9", vm(), -9);
    step(1'b0, 0, 1'b1);
    chk("neg_leak", vm(), -7);

    // invalid weight ignored
    step(1'b0, 5, 1'b0);
    chk("invalid_ignored", vm(), -7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
